// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Purpose  : Receive-side checker for the Prandom Fibonacci LFSR generator.
//            Self-synchronises to the incoming generator state words, reports
//            lock status, per-word match / error pulses and a saturating
//            count of errors seen while locked.
// Ports    : clk          rising-edge clock
//            rst          synchronous active-high reset
//            din_valid_i  qualifies din_i; invalid cycles are ignored
//            din_i        received generator state word (WIDTH bits)
//            clear_cnt_i  synchronous clear of err_count_o
//            locked_o     high while in LOCKED
//            match_o      pulse: previous valid word equalled the prediction
//            err_pulse_o  pulse: previous valid word mispredicted while locked
//            err_count_o  saturating count of locked mispredictions
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker #(
  parameter int              WIDTH    = 3,
  parameter logic [WIDTH-1:0] TAPS    = 3'b110,
  parameter int              LOCK_CNT = 4,
  parameter int              LOSS_CNT = 3,
  parameter int              CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             clear_cnt_i,
  output logic             locked_o,
  output logic             match_o,
  output logic             err_pulse_o,
  output logic [CNT_W-1:0] err_count_o
);

  typedef enum logic [0:0] {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] C_LOCK_CNT = 8'(LOCK_CNT);
  localparam logic [7:0] C_LOSS_CNT = 8'(LOSS_CNT);

  // One Fibonacci LFSR step, shifting left with the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               have_prev_q, have_prev_d;
  logic [7:0]         good_run_q, good_run_d;
  logic [7:0]         bad_run_q, bad_run_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               match_q, match_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_q;
  logic               word_ok;

  // The all-zero word is the LFSR lock-up state and never counts as correct.
  assign word_ok = (din_i == expected_q) && (din_i != '0);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    have_prev_d = have_prev_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    match_d     = 1'b0;
    err_pulse_d = 1'b0;
    // Clear is applied before any increment in the same cycle.
    err_count_d = clear_cnt_i ? '0 : err_count_q;

    if (din_valid_i) begin
      case (state_q)
        S_SEARCH: begin
          // Reseed the prediction from every received word while searching.
          expected_d  = lfsr_next(din_i);
          have_prev_d = 1'b1;
          if (have_prev_q && word_ok) begin
            match_d    = 1'b1;
            good_run_d = good_run_q + 8'd1;
            if (good_run_q + 8'd1 == C_LOCK_CNT) begin
              state_d    = S_LOCKED;
              bad_run_d  = 8'd0;
              good_run_d = 8'd0;
            end
          end else begin
            good_run_d = 8'd0;
          end
        end

        S_LOCKED: begin
          // Flywheel: the prediction free-runs so a corrupted word cannot
          // poison subsequent predictions.
          expected_d = lfsr_next(expected_q);
          if (word_ok) begin
            match_d   = 1'b1;
            bad_run_d = 8'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_d != '1) begin
              err_count_d = err_count_d + CNT_W'(1);
            end
            bad_run_d = bad_run_q + 8'd1;
            if (bad_run_q + 8'd1 == C_LOSS_CNT) begin
              state_d     = S_SEARCH;
              good_run_d  = 8'd0;
              expected_d  = lfsr_next(din_i);
              have_prev_d = 1'b1;
            end
          end
        end

        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SEARCH;
      expected_q  <= '0;
      have_prev_q <= 1'b0;
      good_run_q  <= 8'd0;
      bad_run_q   <= 8'd0;
      err_count_q <= '0;
      match_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      have_prev_q <= have_prev_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      err_count_q <= err_count_d;
      match_q     <= match_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (state_d == S_LOCKED);
    end
  end

  assign locked_o    = locked_q;
  assign match_o     = match_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_checker
// Purpose  : Self-checking bench for prbs_checker. Two instances share the
//            stimulus: default parameters and CNT_W=2 (saturation at 3).
//            Expected outputs come from a behavioural model built on the
//            period-7 sequence table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic [2:0] din = 3'd0;
  logic       clear_cnt = 1'b0;

  logic       locked_a, match_a, err_a;
  logic [7:0] cnt_a;
  logic       locked_b, match_b, err_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prbs_checker dut_a (
    .clk(clk), .rst(rst), .din_valid_i(din_valid), .din_i(din),
    .clear_cnt_i(clear_cnt), .locked_o(locked_a), .match_o(match_a),
    .err_pulse_o(err_a), .err_count_o(cnt_a)
  );

  prbs_checker #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .din_valid_i(din_valid), .din_i(din),
    .clear_cnt_i(clear_cnt), .locked_o(locked_b), .match_o(match_b),
    .err_pulse_o(err_b), .err_count_o(cnt_b)
  );

  // Generator sequence for taps 110 starting at 001.
  int seq [7] = '{1, 2, 5, 3, 7, 6, 4};
  int tx_idx = 0;

  // Behavioural reference state.
  bit m_locked, m_have, m_match, m_err;
  int m_exp, m_good, m_bad, m_cnt;

  function automatic int nxt(input int s);
    for (int i = 0; i < 7; i++)
      if (seq[i] == s) return seq[(i + 1) % 7];
    return 0;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model(input bit r, input bit v, input int d, input bit c);
    bit ok;
    if (r) begin
      m_locked = 0; m_have = 0; m_match = 0; m_err = 0;
      m_exp = 0; m_good = 0; m_bad = 0; m_cnt = 0;
      return;
    end
    m_match = 0; m_err = 0;
    if (c) m_cnt = 0;
    if (!v) return;
    if (!m_locked) begin
      ok = m_have && (d == m_exp) && (d != 0);
      if (ok) begin m_good++; m_match = 1; end
      else m_good = 0;
      m_exp = nxt(d);
      m_have = 1;
      if (m_good == 4) begin m_locked = 1; m_bad = 0; m_good = 0; end
    end else begin
      ok = (d == m_exp) && (d != 0);
      m_exp = nxt(m_exp);
      if (ok) begin m_match = 1; m_bad = 0; end
      else begin
        m_err = 1; m_cnt++; m_bad++;
        if (m_bad == 3) begin
          m_locked = 0; m_good = 0; m_exp = nxt(d); m_have = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input int d, input bit c);
    rst = r; din_valid = v; din = 3'(d); clear_cnt = c;
    @(posedge clk);
    model(r, v, d, c);
    #1;
    chk("locked", {31'd0, locked_a}, {31'd0, m_locked});
    chk("match", {31'd0, match_a}, {31'd0, m_match});
    chk("err_pulse", {31'd0, err_a}, {31'd0, m_err});
    chk("err_count", {24'd0, cnt_a}, 32'(sat(m_cnt, 255)));
    chk("locked_w2", {31'd0, locked_b}, {31'd0, m_locked});
    chk("err_count_w2", {30'd0, cnt_b}, 32'(sat(m_cnt, 3)));
  endtask

  task automatic send_good(input bit c);
    cycle(0, 1, seq[tx_idx], c);
    tx_idx = (tx_idx + 1) % 7;
  endtask

  task automatic send_bad(input bit c);
    cycle(0, 1, 0, c);
    tx_idx = (tx_idx + 1) % 7;
  endtask

  initial begin
    // Reset
    cycle(1, 0, 0, 0);
    // Acquire lock on 001,010,101,011,111
    tx_idx = 0;
    repeat (5) send_good(0);
    // Isolated lock-up word, flywheel keeps predicting 100, 001
    send_bad(0);
    send_good(0);
    send_good(0);
    // Three consecutive wrong words drop lock
    repeat (3) send_bad(0);
    // Resync: first word seeds, next four are correct
    repeat (5) send_good(0);
    // Valid toggling every cycle while locked
    for (int i = 0; i < 8; i++) begin
      send_good(0);
      cycle(0, 0, $urandom_range(0, 7), 0);
    end
    // Clear alone, then clear coincident with an error
    send_good(1);
    send_bad(1);
    // Five locked errors interleaved with good words (saturates CNT_W=2)
    for (int i = 0; i < 5; i++) begin
      send_bad(0);
      send_good(0);
    end
    // Reset while locked
    cycle(1, 1, seq[tx_idx], 0);
    cycle(0, 0, 0, 0);

    // Randomized traffic
    tx_idx = $urandom_range(0, 6);
    for (int i = 0; i < 600; i++) begin
      bit r, v, c;
      int d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) < 85) d = seq[tx_idx];
      else d = $urandom_range(0, 7);
      if ($urandom_range(0, 99) == 0) tx_idx = (tx_idx + 2) % 7;
      cycle(r, v, d, c);
      if (v) tx_idx = (tx_idx + 1) % 7;
    end
    cycle(1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
